// File: rtl/sprite_renderer_if.sv
// Sprite renderer bus: raster input, pending-position writes, ROM port and
// composited pixel output grouped behind master/slave modports.
interface sprite_renderer_if #(
    parameter int ADDRESS    = 10,
    parameter int COLOR_BITS = 24,
    parameter int COORD_BITS = 10
);
    logic                  frame_start;
    logic                  pos_wr;
    logic [COORD_BITS-1:0] pos_x;
    logic [COORD_BITS-1:0] pos_y;
    logic                  pos_en;
    logic [COORD_BITS-1:0] hcount;
    logic [COORD_BITS-1:0] vcount;
    logic                  de;
    logic [COLOR_BITS-1:0] bg_rgb;
    logic [ADDRESS-1:0]    rom_addr;
    logic [COLOR_BITS-1:0] rom_data;
    logic [COLOR_BITS-1:0] rgb_out;
    logic                  de_out;
    logic                  hit_out;
    logic                  hit_frame;

    // Raster/ROM side driving the renderer
    modport master (
        output frame_start, pos_wr, pos_x, pos_y, pos_en,
        output hcount, vcount, de, bg_rgb, rom_data,
        input  rom_addr, rgb_out, de_out, hit_out, hit_frame
    );

    // The renderer itself
    modport slave (
        input  frame_start, pos_wr, pos_x, pos_y, pos_en,
        input  hcount, vcount, de, bg_rgb, rom_data,
        output rom_addr, rgb_out, de_out, hit_out, hit_frame
    );
endinterface

// File: rtl/sprite_renderer.sv
// Two-stage sprite compositor: stage 1 tests the raster position against a
// square sprite and addresses the colour ROM; stage 2 picks sprite or
// background colour from the asynchronous ROM data. Sprite position is
// double-buffered per frame and opaque hits are accumulated per frame.
module sprite_renderer #(
    parameter int                    ADDRESS    = 10,
    parameter int                    COLOR_BITS = 24,
    parameter int                    COORD_BITS = 10,
    parameter logic [COLOR_BITS-1:0] KEY_COLOR  = 24'hFF00FF
) (
    input  logic clk,
    input  logic rst,
    sprite_renderer_if.slave bus
);
    localparam int                  HALF = ADDRESS / 2;
    localparam logic [COORD_BITS:0] SIDE = (COORD_BITS + 1)'(2 ** HALF);

    logic [COORD_BITS-1:0] r_px, r_py, r_ax, r_ay;
    logic                  r_pen, r_aen;
    logic                  r_hit1, r_de1;
    logic [COLOR_BITS-1:0] r_bg1;
    logic [ADDRESS-1:0]    r_rom_addr;
    logic [COLOR_BITS-1:0] r_rgb;
    logic                  r_de_out, r_hit_out;
    logic                  r_acc, r_hit_frame;

    logic [COORD_BITS:0]   w_dx, w_dy;
    logic                  w_hit;
    logic                  w_opaque;

    // Sprite-relative offsets, one bit wider so a sprite near the right or
    // bottom edge is clipped instead of wrapping to coordinate 0
    always_comb begin
        w_dx  = {1'b0, bus.hcount} - {1'b0, r_ax};
        w_dy  = {1'b0, bus.vcount} - {1'b0, r_ay};
        w_hit = r_aen & bus.de
              & (bus.hcount >= r_ax) & (w_dx < SIDE)
              & (bus.vcount >= r_ay) & (w_dy < SIDE);
    end

    // ROM data arrives combinationally for the address registered last cycle
    always_comb begin
        w_opaque = r_hit1 & (bus.rom_data != KEY_COLOR);
    end

    // Pending position written any time; active copy swapped at frame start,
    // taking a same-cycle write directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px  <= '0;
            r_py  <= '0;
            r_pen <= 1'b0;
            r_ax  <= '0;
            r_ay  <= '0;
            r_aen <= 1'b0;
        end else begin
            if (bus.pos_wr) begin
                r_px  <= bus.pos_x;
                r_py  <= bus.pos_y;
                r_pen <= bus.pos_en;
            end
            if (bus.frame_start) begin
                if (bus.pos_wr) begin
                    r_ax  <= bus.pos_x;
                    r_ay  <= bus.pos_y;
                    r_aen <= bus.pos_en;
                end else begin
                    r_ax  <= r_px;
                    r_ay  <= r_py;
                    r_aen <= r_pen;
                end
            end
        end
    end

    // Stage 1: register hit decision, ROM address and delayed background
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit1     <= 1'b0;
            r_de1      <= 1'b0;
            r_bg1      <= '0;
            r_rom_addr <= '0;
        end else begin
            r_hit1     <= w_hit;
            r_de1      <= bus.de;
            r_bg1      <= bus.bg_rgb;
            r_rom_addr <= w_hit ? {w_dy[HALF-1:0], w_dx[HALF-1:0]} : '0;
        end
    end

    // Stage 2: composite sprite over background, blank outside active video
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb     <= '0;
            r_de_out  <= 1'b0;
            r_hit_out <= 1'b0;
        end else begin
            if (!r_de1) begin
                r_rgb <= '0;
            end else if (w_opaque) begin
                r_rgb <= bus.rom_data;
            end else begin
                r_rgb <= r_bg1;
            end
            r_de_out  <= r_de1;
            r_hit_out <= w_opaque & r_de1;
        end
    end

    // Per-frame collision flag; a hit on the closing edge belongs to the old frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 1'b0;
            r_hit_frame <= 1'b0;
        end else if (bus.frame_start) begin
            r_hit_frame <= r_acc | r_hit_out;
            r_acc       <= 1'b0;
        end else if (r_hit_out) begin
            r_acc <= 1'b1;
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.rgb_out   = r_rgb;
    assign bus.de_out    = r_de_out;
    assign bus.hit_out   = r_hit_out;
    assign bus.hit_frame = r_hit_frame;
endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: directed pixel checks with literal expectations
// plus randomized raster traffic compared every cycle to a geometric model.
module tb_sprite_renderer;
    localparam int          SIDE = 32;
    localparam logic [23:0] KEY  = 24'hFF00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] rom [0:1023];

    sprite_renderer_if #(.ADDRESS(10), .COLOR_BITS(24), .COORD_BITS(10)) bus ();

    sprite_renderer #(
        .ADDRESS(10), .COLOR_BITS(24), .COORD_BITS(10), .KEY_COLOR(24'hFF00FF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_px, m_py, m_ax, m_ay;
    logic        m_pen, m_aen;
    int          m_s1_addr;
    logic        m_s1_hit, m_s1_de;
    logic [23:0] m_s1_bg;
    logic [23:0] m_rgb;
    logic        m_de, m_hit, m_acc, m_hf;
    int          mh, mv;
    logic        m_opq;

    // Model: sprite is a square of integer coordinates, no modular arithmetic
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_px = 0; m_py = 0; m_pen = 0;
            m_ax = 0; m_ay = 0; m_aen = 0;
            m_s1_addr = 0; m_s1_hit = 0; m_s1_de = 0; m_s1_bg = '0;
            m_rgb = '0; m_de = 0; m_hit = 0; m_acc = 0; m_hf = 0;
        end else begin
            if (bus.frame_start) begin
                m_hf  = m_acc | m_hit;
                m_acc = 0;
            end else if (m_hit) begin
                m_acc = 1;
            end
            m_opq = m_s1_hit && (rom[m_s1_addr] != KEY);
            m_de  = m_s1_de;
            m_hit = m_opq && m_s1_de;
            m_rgb = !m_s1_de ? 24'h0 : (m_opq ? rom[m_s1_addr] : m_s1_bg);
            mh = int'(bus.hcount);
            mv = int'(bus.vcount);
            m_s1_hit = m_aen && bus.de
                     && mh >= m_ax && mh < m_ax + SIDE
                     && mv >= m_ay && mv < m_ay + SIDE;
            m_s1_addr = m_s1_hit ? (mv - m_ay) * SIDE + (mh - m_ax) : 0;
            m_s1_bg = bus.bg_rgb;
            m_s1_de = bus.de;
            if (bus.frame_start) begin
                if (bus.pos_wr) begin
                    m_ax = int'(bus.pos_x); m_ay = int'(bus.pos_y); m_aen = bus.pos_en;
                end else begin
                    m_ax = m_px; m_ay = m_py; m_aen = m_pen;
                end
            end
            if (bus.pos_wr) begin
                m_px = int'(bus.pos_x); m_py = int'(bus.pos_y); m_pen = bus.pos_en;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rom_addr",  32'(bus.rom_addr),  32'(m_s1_addr[9:0]));
            chk("rgb_out",   32'(bus.rgb_out),   32'(m_rgb));
            chk("de_out",    32'(bus.de_out),    32'(m_de));
            chk("hit_out",   32'(bus.hit_out),   32'(m_hit));
            chk("hit_frame", 32'(bus.hit_frame), 32'(m_hf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_pos(input int x, input int y, input logic en, input logic fs);
        bus.pos_x = 10'(x);
        bus.pos_y = 10'(y);
        bus.pos_en = en;
        bus.pos_wr = 1'b1;
        bus.frame_start = fs;
        @(negedge clk);
        bus.pos_wr = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic px_check(input int h, input int v, input logic [23:0] bg,
                            input logic [9:0] e_addr, input logic [23:0] e_rgb,
                            input logic e_hit, input string name);
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
        bus.de = 1'b1;
        bus.bg_rgb = bg;
        @(negedge clk);
        bus.de = 1'b0;
        chk({name, ".addr"}, 32'(bus.rom_addr), 32'(e_addr));
        @(negedge clk);
        chk({name, ".rgb"}, 32'(bus.rgb_out), 32'(e_rgb));
        chk({name, ".hit"}, 32'(bus.hit_out), 32'(e_hit));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 24'(i);
        rom[5]   = KEY;
        rom[333] = KEY;
        rom[700] = KEY;
        bus.frame_start = 0; bus.pos_wr = 0; bus.pos_x = '0; bus.pos_y = '0;
        bus.pos_en = 0; bus.hcount = '0; bus.vcount = '0; bus.de = 0; bus.bg_rgb = '0;

        repeat (3) @(negedge clk);
        chk("reset.rgb", 32'(bus.rgb_out), 32'h0);
        chk("reset.hit_frame", 32'(bus.hit_frame), 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Hidden until write followed by frame start
        px_check(100, 50, 24'hABCDEF, 10'h0, 24'hABCDEF, 1'b0, "hidden0");
        write_pos(100, 50, 1'b1, 1'b0);
        px_check(100, 50, 24'hABCDEF, 10'h0, 24'hABCDEF, 1'b0, "pending_only");
        frame_pulse();

        // Basic draw
        px_check(100, 50, 24'h111111, 10'h000, 24'h000000, 1'b1, "draw_origin");
        px_check(131, 81, 24'h111111, 10'h3FF, 24'h0003FF, 1'b1, "draw_corner");
        px_check(132, 50, 24'h222222, 10'h000, 24'h222222, 1'b0, "right_out");
        px_check(99, 50, 24'h333333, 10'h000, 24'h333333, 1'b0, "left_out");
        px_check(100, 82, 24'h444444, 10'h000, 24'h444444, 1'b0, "below_out");

        // Transparency
        px_check(105, 50, 24'h123456, 10'h005, 24'h123456, 1'b0, "key_pixel");
        px_check(104, 50, 24'h123456, 10'h004, 24'h000004, 1'b1, "key_neighbour");

        // Double buffering
        write_pos(200, 50, 1'b1, 1'b0);
        px_check(100, 50, 24'h555555, 10'h000, 24'h000000, 1'b1, "midframe_old");
        px_check(200, 50, 24'h555555, 10'h000, 24'h555555, 1'b0, "midframe_new");
        frame_pulse();
        px_check(200, 50, 24'h555555, 10'h000, 24'h000000, 1'b1, "next_new");
        px_check(100, 50, 24'h555555, 10'h000, 24'h555555, 1'b0, "next_old");
        write_pos(300, 60, 1'b1, 1'b1);
        px_check(301, 60, 24'h555555, 10'h001, 24'h000001, 1'b1, "bypass");

        // Edge clip, horizontal and vertical
        write_pos(1010, 0, 1'b1, 1'b1);
        px_check(1010, 0, 24'h666666, 10'd0, 24'd0, 1'b1, "clip_left");
        px_check(1023, 0, 24'h666666, 10'd13, 24'd13, 1'b1, "clip_last");
        px_check(0, 0, 24'h666666, 10'd0, 24'h666666, 1'b0, "clip_col0");
        px_check(17, 0, 24'h666666, 10'd0, 24'h666666, 1'b0, "clip_col17");
        write_pos(1010, 1000, 1'b1, 1'b1);
        px_check(1015, 1023, 24'h777777, 10'd741, 24'd741, 1'b1, "clip_row_last");
        px_check(1015, 0, 24'h777777, 10'd0, 24'h777777, 1'b0, "clip_row0");

        // Collision flag across frames
        write_pos(100, 50, 1'b1, 1'b1);
        px_check(110, 60, 24'h0, 10'd330, 24'd330, 1'b1, "coll_hit");
        write_pos(0, 0, 1'b0, 1'b1);
        chk("hit_frame.set", 32'(bus.hit_frame), 32'h1);
        px_check(110, 60, 24'h0A0A0A, 10'd0, 24'h0A0A0A, 1'b0, "coll_hidden");
        frame_pulse();
        chk("hit_frame.clear", 32'(bus.hit_frame), 32'h0);

        // Hit on the same edge as frame_start belongs to the closing frame
        write_pos(100, 50, 1'b1, 1'b1);
        bus.hcount = 10'd101; bus.vcount = 10'd50; bus.de = 1'b1;
        @(negedge clk);
        bus.de = 1'b0;
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        chk("hit_frame.coincide", 32'(bus.hit_frame), 32'h1);
        frame_pulse();
        chk("hit_frame.after_coincide", 32'(bus.hit_frame), 32'h0);

        // Reset mid-frame while a sprite pixel is on the output
        bus.hcount = 10'd104; bus.vcount = 10'd50; bus.de = 1'b1; bus.bg_rgb = 24'h999999;
        @(posedge clk); @(posedge clk);
        #2;
        chk("pre_rst.hit", 32'(bus.hit_out), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst.rgb", 32'(bus.rgb_out), 32'h0);
        chk("rst.de", 32'(bus.de_out), 32'h0);
        chk("rst.hit", 32'(bus.hit_out), 32'h0);
        chk("rst.addr", 32'(bus.rom_addr), 32'h0);
        bus.de = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        px_check(104, 50, 24'h999999, 10'd0, 24'h999999, 1'b0, "post_rst_hidden");
        write_pos(100, 50, 1'b1, 1'b1);
        px_check(104, 50, 24'h999999, 10'd4, 24'd4, 1'b1, "post_rst_shown");

        // Randomized raster traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.hcount = 10'($urandom);
                bus.vcount = 10'($urandom);
            end else begin
                bus.hcount = 10'(m_ax + int'($urandom_range(0, SIDE + 7)) - 4);
                bus.vcount = 10'(m_ay + int'($urandom_range(0, SIDE + 7)) - 4);
            end
            bus.de = ($urandom_range(0, 3) != 0);
            bus.bg_rgb = 24'($urandom);
            bus.pos_wr = ($urandom_range(0, 49) == 0);
            if (bus.pos_wr) begin
                bus.pos_x = ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                                         : 10'($urandom);
                bus.pos_y = ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                                         : 10'($urandom);
                bus.pos_en = ($urandom_range(0, 3) != 0);
            end
            bus.frame_start = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.pos_wr = 1'b0;
        bus.frame_start = 1'b0;
        bus.de = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Per-pixel sprite compositing stage that sits directly upstream of a sprite colour ROM. Each pixel it takes raster coordinates from the VGA timing generator, decides whether the pixel falls inside a square sprite, and drives the ROM address. It then takes the ROM's asynchronous read data one cycle later and outputs either the sprite colour or the background colour. It also double-buffers the sprite position per frame and reports opaque-pixel hits for collision logic.

## Interface
- ADDRESS, 10, ROM address width; sprite side SIDE = 2^(ADDRESS/2) (32 at default); must be even
- COLOR_BITS, 24, RGB width
- COORD_BITS, 10, width of raster and position coordinates
- KEY_COLOR, 24'hFF00FF, transparent colour; sprite pixels equal to this show the background

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_wr  in  1  write strobe for pending sprite state
- pos_x  in  COORD_BITS  sprite left edge, pixel units
- pos_y  in  COORD_BITS  sprite top edge, pixel units
- pos_en  in  1  sprite visible when 1
- hcount  in  COORD_BITS  current pixel column
- vcount  in  COORD_BITS  current pixel row
- de  in  1  active-video flag aligned with hcount/vcount
- bg_rgb  in  COLOR_BITS  background colour aligned with hcount/vcount
- rom_addr  out  ADDRESS  sprite ROM address, registered, {dy, dx}
- rom_data  in  COLOR_BITS  ROM read data, combinational function of rom_addr
- rgb_out  out  COLOR_BITS  composited pixel
- de_out  out  1  de delayed to match rgb_out
- hit_out  out  1  opaque sprite pixel drawn this cycle
- hit_frame  out  1  sticky: at least one hit_out during the previous frame

## Operation
- **Pending registers (px, py, pen)**
  - Loaded from pos_x/pos_y/pos_en on any cycle with pos_wr=1.
  - Hold their value otherwise.
- **Active registers (ax, ay, aen)**
  - Loaded from the pending registers only on frame_start=1.
  - If pos_wr and frame_start are both 1 in the same cycle, the active registers take the incoming pos_* values directly (bypass), and the pending registers take them as well.
- **Stage 1 (registered on the clk edge after the inputs)**
  - dx = hcount − ax and dy = vcount − ay, each computed COORD_BITS+1 bits wide.
  - hit1 = aen & de & (hcount ≥ ax) & (dx < SIDE) & (vcount ≥ ay) & (dy < SIDE).
  - rom_addr = {dy[ADDRESS/2−1:0], dx[ADDRESS/2−1:0]} when hit1, else 0.
  - bg1 and de1 are delayed copies of bg_rgb and de.
- **No wrap-around**
  - A sprite that extends past coordinate 2^COORD_BITS−1 is clipped.
  - The overflowing columns or rows never appear at coordinate 0.
- **Stage 2 (registered)**
  - opaque = hit1 & (rom_data ≠ KEY_COLOR).
  - rgb_out = 0 when de1=0; rom_data when opaque; bg1 otherwise.
  - de_out = de1.
  - hit_out = opaque & de1.
- **Collision accumulator**
  - An internal flag acc is set by hit_out.
  - On frame_start, acc is copied to hit_frame and acc is cleared.
  - If hit_out and frame_start coincide, the hit counts toward the frame being closed: hit_frame=1 and acc is cleared.
- **Reset values**
  - All of the following are 0 asynchronously while rst=1: px, py, pen, ax, ay, aen, pipeline registers, rom_addr, rgb_out, de_out, hit_out, acc, hit_frame.
  - After reset, the sprite stays hidden until pos_wr with pos_en=1 is followed by a frame_start (or the two occur together).

## Timing
- Latency from hcount/vcount/de/bg_rgb to rgb_out/de_out/hit_out is 2 cycles, with throughput of one pixel per cycle.
- rom_addr changes 1 cycle after its coordinates; rom_data is sampled in the same cycle.
- Position changes take effect on the first pixel after frame_start. Mid-frame pos_wr never alters the current frame.
- hit_frame updates on the edge where frame_start=1 and holds until the next frame_start.
- Reset asserted mid-line blanks the output immediately. After rst is released, the first valid output appears 2 cycles after de.

## Test plan
- **Basic draw:**
  - Stimulus: reset; pos_wr with x=100, y=50, en=1; frame_start; raster scan; ROM loaded with pixel value = address.
  - Required: at (100,50), rgb_out=0x000000 (address 0) 2 cycles later; at (131,81), rom_addr=0x3FF; at (132,50) and (99,50), rgb_out=bg_rgb.
- **Transparency:**
  - Stimulus: ROM word at address 5 = 24'hFF00FF; bg_rgb=0x123456.
  - Required: pixel (105,50) gives rgb_out=0x123456 and hit_out=0; neighbour (104,50) gives hit_out=1.
- **Double buffering:**
  - Stimulus: pos_wr to x=200 mid-frame.
  - Required: remainder of the frame still draws at x=100; after frame_start, draws at 200. With pos_wr and frame_start in the same cycle, the new position is used immediately.
- **Edge clip:**
  - Stimulus: x=1010, y=0.
  - Required: columns 1010–1023 drawn; column 0 is never a hit.
- **Collision flag:**
  - Stimulus: frame with sprite visible, then frame with en=0, each closed by frame_start.
  - Required: hit_frame=1 after the first frame_start, then 0 after the next.
- **Reset mid-frame:**
  - Stimulus: assert rst during a sprite pixel.
  - Required: rgb_out, de_out, hit_out and rom_addr are 0 without waiting for a clk edge; sprite is absent until a new pos_wr and frame_start.
